// File: rtl/regfile_scoreboard_if.sv
// Bus bundle for regfile_scoreboard: write/writeback, two read ports, issue and busy outputs.
// The master modport drives addresses and data; the slave modport is the register file.
interface regfile_scoreboard_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             we_i;
  logic [AW-1:0]    waddr_i;
  logic [WIDTH-1:0] wdata_i;
  logic [AW-1:0]    raddr1_i;
  logic [AW-1:0]    raddr2_i;
  logic             issue_valid_i;
  logic [AW-1:0]    issue_rd_i;
  logic [WIDTH-1:0] rdata1_o;
  logic [WIDTH-1:0] rdata2_o;
  logic             busy1_o;
  logic             busy2_o;
  logic             busy_any_o;

  modport master (
    output we_i, waddr_i, wdata_i, raddr1_i, raddr2_i, issue_valid_i, issue_rd_i,
    input  rdata1_o, rdata2_o, busy1_o, busy2_o, busy_any_o
  );

  modport slave (
    input  we_i, waddr_i, wdata_i, raddr1_i, raddr2_i, issue_valid_i, issue_rd_i,
    output rdata1_o, rdata2_o, busy1_o, busy2_o, busy_any_o
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Parametrised register file with two combinational read ports, optional write bypass and a
// per-register busy scoreboard. Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_scoreboard #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int BYPASS = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_scoreboard_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy_vec;
  logic [DEPTH-1:0] wr_sel;   // writeback addresses entry (clears busy)
  logic [DEPTH-1:0] wr_hit;   // writeback actually changes the stored value

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      localparam bit IsZero = ZeroReg && (gi == 0);
      logic [WIDTH-1:0] data_q, data_d;
      logic             busy_q, busy_d;
      logic             set, clr;

      always_comb begin
        clr    = bus.we_i && (bus.waddr_i == AW'(gi));
        set    = bus.issue_valid_i && (bus.issue_rd_i == AW'(gi)) && !IsZero;
        data_d = (clr && !IsZero) ? bus.wdata_i : data_q;
        // A new issue wins over a completing writeback to the same entry.
        busy_d = set ? 1'b1 : (clr ? 1'b0 : busy_q);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q <= '0;
          busy_q <= 1'b0;
        end else begin
          data_q <= data_d;
          busy_q <= busy_d;
        end
      end

      assign mem[gi]      = data_q;
      assign busy_vec[gi] = busy_q;
      assign wr_sel[gi]   = clr;
      assign wr_hit[gi]   = clr && !IsZero;
    end

    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [AW-1:0]    rd_addr;
      logic [WIDTH-1:0] rd_data;
      logic             rd_busy;

      assign rd_addr = (gi == 0) ? bus.raddr1_i : bus.raddr2_i;

      // Decoding by compare leaves out-of-range addresses at zero data and not busy.
      always_comb begin
        rd_data = '0;
        rd_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          if (rd_addr == AW'(i)) begin
            rd_data = mem[i];
            rd_busy = busy_vec[i];
            if (BYPASS != 0 && wr_hit[i]) rd_data = bus.wdata_i;
            if (BYPASS != 0 && wr_sel[i]) rd_busy = 1'b0;
          end
        end
        if (!rst_n) begin
          rd_data = '0;
          rd_busy = 1'b0;
        end
      end
    end
  endgenerate

  assign bus.rdata1_o   = g_rd[0].rd_data;
  assign bus.rdata2_o   = g_rd[1].rd_data;
  assign bus.busy1_o    = g_rd[0].rd_busy;
  assign bus.busy2_o    = g_rd[1].rd_busy;
  assign bus.busy_any_o = rst_n && (|busy_vec);
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: bypass and non-bypass 8x8 instances plus a
// DEPTH=6 instance for out-of-range and register-0 behaviour.
`timescale 1ns/1ps
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  regfile_scoreboard_if #(.WIDTH(8), .DEPTH(8)) if_b1 ();
  regfile_scoreboard_if #(.WIDTH(8), .DEPTH(8)) if_b0 ();
  regfile_scoreboard_if #(.WIDTH(8), .DEPTH(6)) if_d6 ();

  regfile_scoreboard #(.WIDTH(8), .DEPTH(8), .BYPASS(1)) dut_b1 (.clk(clk), .rst_n(rst_n), .bus(if_b1));
  regfile_scoreboard #(.WIDTH(8), .DEPTH(8), .BYPASS(0)) dut_b0 (.clk(clk), .rst_n(rst_n), .bus(if_b0));
  regfile_scoreboard #(.WIDTH(8), .DEPTH(6), .BYPASS(1)) dut_d6 (.clk(clk), .rst_n(rst_n), .bus(if_d6));

  // The two 8-deep instances share one stimulus.
  logic       we, issue_valid;
  logic [2:0] waddr, raddr1, raddr2, issue_rd;
  logic [7:0] wdata;

  assign if_b1.we_i = we;           assign if_b0.we_i = we;
  assign if_b1.waddr_i = waddr;     assign if_b0.waddr_i = waddr;
  assign if_b1.wdata_i = wdata;     assign if_b0.wdata_i = wdata;
  assign if_b1.raddr1_i = raddr1;   assign if_b0.raddr1_i = raddr1;
  assign if_b1.raddr2_i = raddr2;   assign if_b0.raddr2_i = raddr2;
  assign if_b1.issue_valid_i = issue_valid; assign if_b0.issue_valid_i = issue_valid;
  assign if_b1.issue_rd_i = issue_rd;       assign if_b0.issue_rd_i = issue_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    we = 1'b1; waddr = 3'd3; wdata = 8'hA5; raddr1 = 3'd3; raddr2 = 3'd0;
    issue_valid = 1'b1; issue_rd = 3'd3;
    if_d6.we_i = 1'b0; if_d6.waddr_i = '0; if_d6.wdata_i = '0; if_d6.raddr1_i = '0;
    if_d6.raddr2_i = '0; if_d6.issue_valid_i = 1'b0; if_d6.issue_rd_i = '0;

    // Reset holds everything at zero even with bypass-eligible stimulus present.
    #2;
    check("rst_rdata1_b1", 32'(if_b1.rdata1_o), 32'h0);
    check("rst_busy_any_b1", 32'(if_b1.busy_any_o), 32'h0);
    repeat (2) @(negedge clk);
    check("rst_hold_rdata1_b0", 32'(if_b0.rdata1_o), 32'h0);

    @(negedge clk);
    rst_n = 1'b1; issue_valid = 1'b0;
    #1;
    check("byp_wr_r3_b1", 32'(if_b1.rdata1_o), 32'hA5);
    check("nobyp_wr_r3_b0", 32'(if_b0.rdata1_o), 32'h0);
    check("rst_issue_dropped_b0", 32'(if_b0.busy1_o), 32'h0);

    @(negedge clk); we = 1'b0;
    #1;
    check("stored_r3_b0", 32'(if_b0.rdata1_o), 32'hA5);
    check("stored_r3_b1", 32'(if_b1.rdata1_o), 32'hA5);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); raddr1 = 3'(i);
      #1;
      check($sformatf("scan_r%0d_b0", i), 32'(if_b0.rdata1_o), (i == 3) ? 32'hA5 : 32'h0);
    end

    // Bypass versus stored-only read of r5.
    @(negedge clk); we = 1'b1; waddr = 3'd5; wdata = 8'h11;
    @(negedge clk); wdata = 8'h3C; raddr2 = 3'd5;
    #1;
    check("byp_rdata2_b1", 32'(if_b1.rdata2_o), 32'h3C);
    check("old_rdata2_b0", 32'(if_b0.rdata2_o), 32'h11);
    @(negedge clk); we = 1'b0; raddr1 = 3'd5;
    #1;
    check("new_rdata2_b0", 32'(if_b0.rdata2_o), 32'h3C);
    check("same_addr_rdata1_b0", 32'(if_b0.rdata1_o), 32'h3C);

    // Scoreboard: issue r2, complete it three cycles later.
    @(negedge clk); issue_valid = 1'b1; issue_rd = 3'd2; raddr1 = 3'd2;
    #1;
    check("issue_no_fwd_b1", 32'(if_b1.busy1_o), 32'h0);
    check("issue_no_fwd_any_b1", 32'(if_b1.busy_any_o), 32'h0);
    @(negedge clk); issue_valid = 1'b0;
    #1;
    check("busy_c1_b0", 32'(if_b0.busy1_o), 32'h1);
    check("busy_c1_b1", 32'(if_b1.busy1_o), 32'h1);
    check("busy_any_c1_b1", 32'(if_b1.busy_any_o), 32'h1);
    @(negedge clk);
    @(negedge clk); we = 1'b1; waddr = 3'd2; wdata = 8'h77;
    #1;
    check("busy_masked_c3_b1", 32'(if_b1.busy1_o), 32'h0);
    check("busy_held_c3_b0", 32'(if_b0.busy1_o), 32'h1);
    check("busy_any_c3_b1", 32'(if_b1.busy_any_o), 32'h1);
    @(negedge clk); we = 1'b0; raddr2 = 3'd3;
    #1;
    check("busy_clr_c4_b0", 32'(if_b0.busy1_o), 32'h0);
    check("busy_clr_c4_b1", 32'(if_b1.busy1_o), 32'h0);
    check("busy_any_c4_b0", 32'(if_b0.busy_any_o), 32'h0);
    check("wb_data_r2_b0", 32'(if_b0.rdata1_o), 32'h77);
    check("not_busy_wr_r3_b0", 32'(if_b0.busy2_o), 32'h0);

    // Issue and writeback to r4 in the same cycle: busy stays set, data lands.
    @(negedge clk); issue_valid = 1'b1; issue_rd = 3'd4; we = 1'b1; waddr = 3'd4;
    wdata = 8'h4D; raddr1 = 3'd4;
    @(negedge clk); issue_valid = 1'b0; we = 1'b0;
    #1;
    check("sim_busy_r4_b0", 32'(if_b0.busy1_o), 32'h1);
    check("sim_data_r4_b0", 32'(if_b0.rdata1_o), 32'h4D);
    check("sim_busy_any_b1", 32'(if_b1.busy_any_o), 32'h1);

    // Asynchronous reset between edges with r1 and r6 in flight.
    @(negedge clk); issue_valid = 1'b1; issue_rd = 3'd1;
    @(negedge clk); issue_rd = 3'd6;
    @(negedge clk); issue_valid = 1'b0; raddr1 = 3'd1; raddr2 = 3'd6;
    #1;
    check("pre_rst_busy1_b0", 32'(if_b0.busy1_o), 32'h1);
    check("pre_rst_busy2_b0", 32'(if_b0.busy2_o), 32'h1);
    #1; rst_n = 1'b0;
    #1;
    check("async_busy1_b0", 32'(if_b0.busy1_o), 32'h0);
    check("async_busy2_b0", 32'(if_b0.busy2_o), 32'h0);
    check("async_busy_any_b1", 32'(if_b1.busy_any_o), 32'h0);
    raddr1 = 3'd4;
    #1; rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("post_rst_r4_b0", 32'(if_b0.rdata1_o), 32'h0);
    check("post_rst_busy_any_b1", 32'(if_b1.busy_any_o), 32'h0);
    check("post_rst_busy_any_b0", 32'(if_b0.busy_any_o), 32'h0);

    // DEPTH=6: out-of-range writes, reads and issues.
    @(negedge clk);
    if_d6.we_i = 1'b1; if_d6.waddr_i = 3'd7; if_d6.wdata_i = 8'hEE; if_d6.raddr1_i = 3'd7;
    if_d6.issue_valid_i = 1'b1; if_d6.issue_rd_i = 3'd7;
    #1;
    check("oor7_rdata1_d6", 32'(if_d6.rdata1_o), 32'h0);
    @(negedge clk);
    if_d6.waddr_i = 3'd6; if_d6.issue_rd_i = 3'd6; if_d6.raddr1_i = 3'd6;
    #1;
    check("oor6_rdata1_d6", 32'(if_d6.rdata1_o), 32'h0);
    @(negedge clk); if_d6.we_i = 1'b0; if_d6.issue_valid_i = 1'b0;
    #1;
    check("oor_busy_any_d6", 32'(if_d6.busy_any_o), 32'h0);
    check("oor_busy1_d6", 32'(if_d6.busy1_o), 32'h0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); if_d6.raddr1_i = 3'(i);
      #1;
      check($sformatf("oor_scan_r%0d_d6", i), 32'(if_d6.rdata1_o), 32'h0);
    end

    // Register 0: hardwired when the zero-register feature is built in.
    @(negedge clk);
    if_d6.we_i = 1'b1; if_d6.waddr_i = 3'd0; if_d6.wdata_i = 8'hFF; if_d6.raddr1_i = 3'd0;
    if_d6.issue_valid_i = 1'b1; if_d6.issue_rd_i = 3'd0;
    #1;
    check("r0_bypass_d6", 32'(if_d6.rdata1_o), ZERO ? 32'h0 : 32'hFF);
    @(negedge clk); if_d6.we_i = 1'b0; if_d6.issue_valid_i = 1'b0;
    #1;
    check("r0_stored_d6", 32'(if_d6.rdata1_o), ZERO ? 32'h0 : 32'hFF);
    check("r0_busy1_d6", 32'(if_d6.busy1_o), ZERO ? 32'h0 : 32'h1);
    check("r0_busy_any_d6", 32'(if_d6.busy_any_o), ZERO ? 32'h0 : 32'h1);

    @(negedge clk);
    if_d6.we_i = 1'b1; if_d6.waddr_i = 3'd5; if_d6.wdata_i = 8'h5A; if_d6.raddr2_i = 3'd5;
    @(negedge clk); if_d6.we_i = 1'b0;
    #1;
    check("r5_stored_d6", 32'(if_d6.rdata2_o), 32'h5A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
